// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the round transformations.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    localparam byte_t AES_POLY = 8'h1b;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t gmul3(input byte_t x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_columns_if.sv
// State/valid bundle between shift_rows and add_round_key around mix_columns.
interface mix_columns_if;
    import aes_pkg::*;

    logic   valid_i;
    state_t state_i;
    logic   valid_o;
    state_t state_o;

    modport master (output valid_i, output state_i, input valid_o, input state_o);
    modport slave  (input valid_i, input state_i, output valid_o, output state_o);

endinterface

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one 32-bit column; a0/b0 sit in the top byte.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    byte_t w_a0, w_a1, w_a2, w_a3;
    byte_t w_b0, w_b1, w_b2, w_b3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign w_b0 = xtime(w_a0) ^ gmul3(w_a1) ^ w_a2        ^ w_a3;
    assign w_b1 = w_a0        ^ xtime(w_a1) ^ gmul3(w_a2) ^ w_a3;
    assign w_b2 = w_a0        ^ w_a1        ^ xtime(w_a2) ^ gmul3(w_a3);
    assign w_b3 = gmul3(w_a0) ^ w_a1        ^ w_a2        ^ xtime(w_a3);

    assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns on a full 128-bit state, one state per cycle, one cycle latency.
module mix_columns
    import aes_pkg::*;
(
    input logic         clk,
    input logic         rst,
    mix_columns_if.slave bus
);

    state_t w_mixed_p0;
    logic   r_vld_p1;
    state_t r_state_p1;

    // Stage p0: four columns mixed in parallel; column c is bytes 4c..4c+3 from the MSB.
    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_column u_col (
            .i_col (bus.state_i[127-32*c -: 32]),
            .o_col (w_mixed_p0[127-32*c -: 32])
        );
    end

    // Stage p1: output registers; state holds while no valid input arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_state_p1 <= '0;
        end else begin
            r_vld_p1 <= bus.valid_i;
            if (bus.valid_i) begin
                r_state_p1 <= w_mixed_p0;
            end
        end
    end

    assign bus.valid_o = r_vld_p1;
    assign bus.state_o = r_state_p1;

endmodule

// File: tb/tb_mix_columns.sv
// Randomized and directed bench for mix_columns against a matrix-form GF(2^8) model.
module tb_mix_columns;
    import aes_pkg::*;

    logic clk;
    logic rst;
    mix_columns_if bus();

    mix_columns dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    bit     chk_en = 0;
    bit     exp_v  = 0;
    state_t exp_s  = '0;

    // Generic shift-and-add multiply with reduction by the full 9-bit polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
        end
        return p;
    endfunction

    // Circulant matrix rows are [2 3 1 1] rotated right by the row index.
    function automatic state_t model(input state_t s);
        logic [7:0] base [4];
        logic [7:0] a [4];
        logic [7:0] b;
        state_t     r;
        base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c+k) -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gf_mul(base[(j - row + 4) % 4], a[j]);
                r[127 - 8*(4*c+row) -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input state_t act, input state_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %032h expected %032h", name, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Apply inputs for one edge, then record what the outputs must show afterwards.
    task automatic drive(input bit v, input state_t s);
        bus.valid_i = v;
        bus.state_i = s;
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) exp_s = model(s);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.valid_o !== exp_v || bus.state_o !== exp_s) begin
                errors++;
                $display("FAIL cycle_compare t=%0t: got v=%b s=%032h expected v=%b s=%032h",
                         $time, bus.valid_o, bus.state_o, exp_v, exp_s);
            end
        end
    end

    logic [31:0] col_in  [10];
    logic [31:0] col_out [10];
    state_t      fips_in, fips_out, st, held;

    initial begin
        col_in[0] = 32'hdb135345; col_out[0] = 32'h8e4da1bc;
        col_in[1] = 32'hf20a225c; col_out[1] = 32'h9fdc589d;
        col_in[2] = 32'h01010101; col_out[2] = 32'h01010101;
        col_in[3] = 32'hc6c6c6c6; col_out[3] = 32'hc6c6c6c6;
        col_in[4] = 32'hd4d4d4d5; col_out[4] = 32'hd5d5d7d6;
        col_in[5] = 32'h2d26314c; col_out[5] = 32'h4d7ebdf8;
        col_in[6] = 32'h00000000; col_out[6] = 32'h00000000;
        col_in[7] = 32'hffffffff; col_out[7] = 32'hffffffff;
        col_in[8] = 32'h80808080; col_out[8] = 32'h80808080;
        col_in[9] = 32'h80000000; col_out[9] = 32'h1b80809b;
        fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;

        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.state_i = '0;
        #2;
        check_bit("reset_valid", bus.valid_o, 1'b0);
        check("reset_state", bus.state_o, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the model to hand-computed vectors before trusting it for the DUT.
        check("model_fips", model(fips_in), fips_out);
        for (int i = 0; i < 10; i++) begin
            st = {col_in[i], {3{32'h01010101}}};
            check($sformatf("model_col%0d", i), model(st), {col_out[i], {3{32'h01010101}}});
        end

        chk_en = 1;
        for (int i = 0; i < 10; i++) begin
            st = {col_in[i], {3{32'h01010101}}};
            drive(1'b1, st);
            check($sformatf("dut_col%0d", i), bus.state_o, {col_out[i], {3{32'h01010101}}});
        end
        drive(1'b1, {4{32'h80000000}});
        check("dut_xtime_all_cols", bus.state_o, {4{32'h1b80809b}});

        drive(1'b1, fips_in);
        check("dut_fips", bus.state_o, fips_out);
        check_bit("dut_fips_valid", bus.valid_o, 1'b1);

        // Idle and hold.
        held = exp_s;
        for (int i = 0; i < 4; i++) drive(1'b0, '0);
        check("hold_state", bus.state_o, held);
        check_bit("hold_valid", bus.valid_o, 1'b0);

        // Nine back-to-back states, then valid drops.
        for (int i = 0; i < 9; i++) drive(1'b1, {$urandom, $urandom, $urandom, $urandom});
        drive(1'b0, '0);
        check_bit("stream_tail_valid", bus.valid_o, 1'b0);

        // Random valid pattern.
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom});

        // Asynchronous reset between edges while a result is valid.
        drive(1'b1, fips_in);
        chk_en = 0;
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_rst_valid", bus.valid_o, 1'b0);
        check("async_rst_state", bus.state_o, '0);
        bus.valid_i = 1'b1;
        bus.state_i = fips_in;
        @(posedge clk);
        #1;
        check_bit("rst_held_valid", bus.valid_o, 1'b0);
        check("rst_held_state", bus.state_o, '0);
        bus.valid_i = 1'b0;
        rst = 1'b0;
        exp_v = 0;
        exp_s = '0;
        chk_en = 1;
        drive(1'b1, fips_in);
        check("post_rst_fips", bus.state_o, fips_out);
        for (int i = 0; i < 20; i++)
            drive(($urandom_range(0, 1) != 0), {$urandom, $urandom, $urandom, $urandom});
        drive(1'b0, '0);
        @(posedge clk);
        #1;
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
